vga_frame_checker: RTL and testbench
====================================

Name: vga_frame_checker

Overview:
Receive-side monitor for the VGA output of the display renderer. It consumes hsync, vsync, blank and the 6-bit colour, rebuilds the active-area geometry, and computes a CRC-16 over every active pixel of each frame. Once per frame it reports the CRC, the measured width and height, a geometry error flag, and a lock status. It sits in the test/debug harness beside the display path, tapping the same registered output signals.

Parameters:
H_ACTIVE, 640, expected active pixels per line
V_ACTIVE, 480, expected active lines per frame
SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low; 0 = asserted high
TIMEOUT_LOG2, 20, log2 of cycles without a vsync edge before the checker drops to IDLE

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, synchronous, active-low
hsync  in  1  horizontal sync from display
vsync  in  1  vertical sync from display
blank  in  1  1 = outside active area
colour  in  6  pixel colour, valid when blank=0
frame_valid  out  1  single-cycle pulse: report outputs updated
frame_crc  out  16  CRC of the last completed frame
active_w  out  10  active width of the first active line of that frame
active_h  out  10  number of lines with at least one active pixel
err_geometry  out  1  last frame had unequal line widths, or saturated
locked  out  1  stable expected geometry

Behaviour:
- Reset, clock and all other: reset rst_n, synchronous, active-low; clock clk. On reset every output is 0, state is IDLE, and all counters and the CRC are cleared.
- Input stage: hsync, vsync, blank and colour are registered once. Sync levels are normalised by SYNC_ACTIVE_LOW. An edge means a transition from deasserted to asserted in the registered level.
- States: IDLE and CAPTURE.
  - IDLE to CAPTURE on the first vsync edge. Nothing is reported for that partial frame.
  - CAPTURE to CAPTURE on each vsync edge: report the frame, then clear the accumulators.
  - Any state to IDLE on timeout. locked clears; report registers hold their values.
- Pixel path: on each registered cycle with blank=0 in CAPTURE:
  - x_cnt increments, saturating at 1023.
  - The CRC updates with byte {2'b00,colour}.
  - CRC is CRC-16-CCITT: poly 0x1021, init 0xFFFF, MSB first, no reflection, no final XOR. One byte per cycle.
- Line close (hsync edge) when x_cnt != 0:
  - y_cnt increments, saturating at 1023.
  - The first line of the frame stores line_w = x_cnt.
  - Later lines with x_cnt != line_w set the mismatch flag.
  - x_cnt clears.
  - If x_cnt == 0, nothing changes.
- Frame report (vsync edge in CAPTURE):
  - An open line (x_cnt != 0) is closed first, exactly as a line close. This also applies when hsync and vsync edges coincide.
  - Then frame_crc, active_w, active_h and err_geometry load, and frame_valid pulses for 1 cycle.
  - err_geometry = mismatch OR either counter saturated.
  - CRC resets to 0xFFFF; x_cnt, y_cnt and mismatch clear.
  - Latency: frame_valid asserts 2 cycles after the raw vsync edge (1 input register + 1 report register).
- Lock:
  - good frame = (active_w==H_ACTIVE) AND (active_h==V_ACTIVE) AND NOT err_geometry.
  - locked sets on the second consecutive good frame and clears on any bad frame or timeout.
- Timeout counter (TIMEOUT_LOG2 bits): cleared by every vsync edge; expiry is the counter reaching all-ones.
- Pixels while blank=0 during vsync are still counted. No special-casing.
- Reset mid-frame: discard everything and return to IDLE.

Optional Feature:
VGA_CHECK_FRAME_COUNT_EN:
- Defined: adds output port frame_count [15:0]. It increments with each frame_valid, wraps 0xFFFF to 0, resets to 0, and is not cleared by timeout.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package vga_check_pkg holds:
  - the state enum (IDLE, CAPTURE);
  - CRC16_POLY = 16'h1021 and CRC16_INIT = 16'hFFFF;
  - a pure function crc16_byte(crc, byte) returning the next CRC.
- Sub-module vga_crc16: clear/enable/data in, 16-bit register out, using the package function.
- Sync normalisation, counters and the state machine stay in vga_frame_checker.

Test Plan:
- H_ACTIVE=9, V_ACTIVE=1; one line with colours 0x31..0x39, framed by vsync edges -> frame_crc=16'h29B1, active_w=9, active_h=1, err_geometry=0, frame_valid exactly 1 cycle, 2 cycles after the vsync edge.
- Default params; two full 640x480 frames of colour 6'h3c -> locked=0 after the first report and 1 after the second; frame_crc matches a model and is equal for both frames.
- Line 3 of 480 has 639 active pixels -> err_geometry=1, locked drops to 0; the next good frame gives err_geometry=0 with locked still 0; one more good frame gives locked=1.
- Stop vsync while locked for 2^20 cycles -> locked=0, state IDLE; the first new vsync gives no report and the second gives a report.
- hsync and vsync edges in the same cycle while x_cnt=5 on line 2 -> active_h counts that line, and active_w is checked against it.
- SYNC_ACTIVE_LOW=0 with high-true syncs, plus reset asserted mid-frame -> all outputs 0; the first full frame after two vsync edges reports correctly; with VGA_CHECK_FRAME_COUNT_EN, frame_count reads 1.

Source files
------------

// File: rtl/vga_check_pkg.sv
// Shared types, CRC-16-CCITT constants and the per-byte CRC step for the VGA frame checker.
package vga_check_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [9:0]  CNT_MAX    = 10'h3FF;

    // MSB-first, unreflected CRC-16-CCITT step over one byte.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_crc16.sv
// CRC-16-CCITT accumulator, one byte per enabled cycle; clear restarts from the init value.
// Latency: result visible the cycle after the byte is presented.
// Backpressure: none, consumes data on every enabled cycle.
module vga_crc16
    import vga_check_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    // A clear with enable set seeds the new run with this cycle's byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= enable ? crc16_byte(CRC16_INIT, data) : CRC16_INIT;
        end else if (enable) begin
            crc <= crc16_byte(crc, data);
        end
    end

endmodule

// File: rtl/vga_frame_checker.sv
// VGA receive monitor: rebuilds active geometry, CRCs active pixels, reports once per frame, tracks lock.
// Latency: frame_valid 2 cycles after the raw vsync edge. Optional frame_count via VGA_CHECK_FRAME_COUNT_EN.
// Backpressure: none; a passive tap that samples every pixel clock.
module vga_frame_checker
    import vga_check_pkg::*;
#(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int TIMEOUT_LOG2    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic [5:0]  colour,
    output logic        frame_valid,
    output logic [15:0] frame_crc,
    output logic [9:0]  active_w,
    output logic [9:0]  active_h,
    output logic        err_geometry,
    output logic        locked
`ifdef VGA_CHECK_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam logic       SYNC_POL = (SYNC_ACTIVE_LOW != 0);
    localparam logic [9:0] H_EXP    = 10'(H_ACTIVE);
    localparam logic [9:0] V_EXP    = 10'(V_ACTIVE);

    logic        hs_r, vs_r, hs_q, vs_q, blank_r;
    logic [5:0]  colour_r;
    state_t      state;
    logic [9:0]  x_cnt, y_cnt, line_w;
    logic        mismatch, sat, prev_good;
    logic [TIMEOUT_LOG2-1:0] to_cnt;
    logic [15:0] crc;

    logic        hs_edge, vs_edge, in_cap, pix, close, expired, good;
    logic [9:0]  y_cl, w_cl;
    logic        mm_cl, sat_cl;

    // Sync levels are normalised to 1 = asserted before registering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_r     <= 1'b0;
            vs_r     <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            blank_r  <= 1'b1;
            colour_r <= '0;
        end else begin
            hs_r     <= hsync ^ SYNC_POL;
            vs_r     <= vsync ^ SYNC_POL;
            hs_q     <= hs_r;
            vs_q     <= vs_r;
            blank_r  <= blank;
            colour_r <= colour;
        end
    end

    assign hs_edge = hs_r & ~hs_q;
    assign vs_edge = vs_r & ~vs_q;
    assign in_cap  = (state == CAPTURE);
    assign pix     = ~blank_r & (in_cap | vs_edge);
    assign close   = in_cap & (hs_edge | vs_edge) & (x_cnt != '0);
    assign expired = &to_cnt;

    // Accumulator values after closing any open line this cycle; the report samples these.
    always_comb begin
        y_cl   = y_cnt;
        w_cl   = line_w;
        mm_cl  = mismatch;
        sat_cl = sat;
        if (close) begin
            y_cl   = (y_cnt == CNT_MAX) ? y_cnt : y_cnt + 10'd1;
            sat_cl = sat | (x_cnt == CNT_MAX) | (y_cnt >= CNT_MAX - 10'd1);
            if (y_cnt == '0) begin
                w_cl = x_cnt;
            end else if (x_cnt != line_w) begin
                mm_cl = 1'b1;
            end
        end
    end

    assign good = (w_cl == H_EXP) & (y_cl == V_EXP) & ~(mm_cl | sat_cl);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            x_cnt        <= '0;
            y_cnt        <= '0;
            line_w       <= '0;
            mismatch     <= 1'b0;
            sat          <= 1'b0;
            prev_good    <= 1'b0;
            to_cnt       <= '0;
            frame_valid  <= 1'b0;
            frame_crc    <= '0;
            active_w     <= '0;
            active_h     <= '0;
            err_geometry <= 1'b0;
            locked       <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            to_cnt      <= expired ? to_cnt : to_cnt + 1'b1;
            if (vs_edge) begin
                to_cnt <= '0;
                state  <= CAPTURE;
                if (in_cap) begin
                    frame_valid  <= 1'b1;
                    frame_crc    <= crc;
                    active_w     <= w_cl;
                    active_h     <= y_cl;
                    err_geometry <= mm_cl | sat_cl;
                    locked       <= good & prev_good;
                    prev_good    <= good;
                end
                x_cnt    <= {9'd0, pix};
                y_cnt    <= '0;
                line_w   <= '0;
                mismatch <= 1'b0;
                sat      <= 1'b0;
            end else if (expired) begin
                state     <= IDLE;
                locked    <= 1'b0;
                prev_good <= 1'b0;
            end else if (in_cap) begin
                y_cnt    <= y_cl;
                line_w   <= w_cl;
                mismatch <= mm_cl;
                sat      <= sat_cl;
                if (close) begin
                    x_cnt <= {9'd0, pix};
                end else if (pix && x_cnt != CNT_MAX) begin
                    x_cnt <= x_cnt + 10'd1;
                end
            end
        end
    end

    vga_crc16 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (vs_edge),
        .enable (pix),
        .data   ({2'b00, colour_r}),
        .crc    (crc)
    );

`ifdef VGA_CHECK_FRAME_COUNT_EN
    // Survives timeouts; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (vs_edge && in_cap) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_frame_checker.sv
// Bench for vga_frame_checker: one stimulus drives an active-low and an active-high sync instance.
module tb_vga_frame_checker;

    localparam int H = 9;
    localparam int V = 4;
    localparam int TO_LOG2 = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       hs_lvl, vs_lvl, blank;
    logic [5:0] colour;

    logic        fv[2];
    logic [15:0] crc[2];
    logic [9:0]  aw[2];
    logic [9:0]  ah[2];
    logic        err[2];
    logic        lck[2];
`ifdef VGA_CHECK_FRAME_COUNT_EN
    logic [15:0] fcnt[2];
`endif

    vga_frame_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE_LOW(1), .TIMEOUT_LOG2(TO_LOG2)) dut0 (
        .clk(clk), .rst_n(rst_n), .hsync(~hs_lvl), .vsync(~vs_lvl), .blank(blank), .colour(colour),
        .frame_valid(fv[0]), .frame_crc(crc[0]), .active_w(aw[0]), .active_h(ah[0]),
        .err_geometry(err[0]), .locked(lck[0])
`ifdef VGA_CHECK_FRAME_COUNT_EN
        , .frame_count(fcnt[0])
`endif
    );

    vga_frame_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE_LOW(0), .TIMEOUT_LOG2(TO_LOG2)) dut1 (
        .clk(clk), .rst_n(rst_n), .hsync(hs_lvl), .vsync(vs_lvl), .blank(blank), .colour(colour),
        .frame_valid(fv[1]), .frame_crc(crc[1]), .active_w(aw[1]), .active_h(ah[1]),
        .err_geometry(err[1]), .locked(lck[1])
`ifdef VGA_CHECK_FRAME_COUNT_EN
        , .frame_count(fcnt[1])
`endif
    );

    typedef struct {
        logic [15:0] crc;
        logic [9:0]  w;
        logic [9:0]  h;
        logic        err;
        logic        lck;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_fv[2];

    // Reference model state, following the behavioural description.
    logic        m_cap, m_mm, m_prev;
    logic [15:0] m_crc, m_count;
    int          m_x, m_h, m_w;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [5:0] col);
        logic [15:0] c;
        logic [7:0]  d;
        logic        fb;
        c = c_in;
        d = {2'b00, col};
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic cmp(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, act, exp);
        end
    endtask

    task automatic mon_report(input int d);
        exp_t e;
        checks++;
        if (prev_fv[d]) begin
            errors++;
            $display("FAIL pulse_width dut%0d: frame_valid high 2 cycles, expected 1", d);
        end
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_report dut%0d: frame_valid at cycle %0d, expected none", d, cyc);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        cmp("latency", d, 32'(cyc), 32'(e.cyc));
        cmp("frame_crc", d, 32'(crc[d]), 32'(e.crc));
        cmp("active_w", d, 32'(aw[d]), 32'(e.w));
        cmp("active_h", d, 32'(ah[d]), 32'(e.h));
        cmp("err_geometry", d, 32'(err[d]), 32'(e.err));
        cmp("locked", d, 32'(lck[d]), 32'(e.lck));
`ifdef VGA_CHECK_FRAME_COUNT_EN
        cmp("frame_count", d, 32'(fcnt[d]), 32'(e.cnt));
`endif
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (fv[d] === 1'b1) mon_report(d);
            prev_fv[d] <= fv[d];
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_close();
        if (m_cap && m_x != 0) begin
            if (m_h == 0) m_w = m_x;
            else if (m_x != m_w) m_mm = 1'b1;
            m_h++;
            m_x = 0;
        end
    endtask

    task automatic model_clear();
        m_crc = 16'hFFFF;
        m_x = 0;
        m_h = 0;
        m_w = 0;
        m_mm = 1'b0;
    endtask

    task automatic pixels(input int n, input logic [5:0] c0, input int step);
        for (int i = 0; i < n; i++) begin
            blank  = 1'b0;
            colour = c0 + 6'(i * step);
            if (m_cap) begin
                m_crc = crc_model(m_crc, colour);
                m_x++;
            end
            tick();
        end
        blank  = 1'b1;
        colour = '0;
    endtask

    task automatic hpulse();
        hs_lvl = 1'b1;
        model_close();
        tick(2);
        hs_lvl = 1'b0;
        tick(2);
    endtask

    task automatic line(input int n, input logic [5:0] c0, input int step);
        pixels(n, c0, step);
        tick();
        hpulse();
    endtask

    // A vsync edge closes any open line and, when capturing, queues the expected report.
    task automatic vpulse(input bit with_h);
        exp_t e;
        logic good;
        vs_lvl = 1'b1;
        if (with_h) hs_lvl = 1'b1;
        if (m_cap) begin
            model_close();
            good    = (m_w == H) && (m_h == V) && !m_mm;
            e.crc   = m_crc;
            e.w     = 10'(m_w);
            e.h     = 10'(m_h);
            e.err   = m_mm;
            e.lck   = good && m_prev;
            m_prev  = good;
            m_count = m_count + 16'd1;
            e.cnt   = m_count;
            e.cyc   = cyc + 2;
            q0.push_back(e);
            q1.push_back(e);
        end
        model_clear();
        m_cap = 1'b1;
        tick(2);
        vs_lvl = 1'b0;
        hs_lvl = 1'b0;
        tick(2);
    endtask

    task automatic good_frame(input logic [5:0] c);
        for (int l = 0; l < V; l++) line(H, c, 0);
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            cmp({tag, "_frame_valid"}, d, 32'(fv[d]), 32'd0);
            cmp({tag, "_frame_crc"}, d, 32'(crc[d]), 32'd0);
            cmp({tag, "_active_w"}, d, 32'(aw[d]), 32'd0);
            cmp({tag, "_active_h"}, d, 32'(ah[d]), 32'd0);
            cmp({tag, "_err_geometry"}, d, 32'(err[d]), 32'd0);
            cmp({tag, "_locked"}, d, 32'(lck[d]), 32'd0);
`ifdef VGA_CHECK_FRAME_COUNT_EN
            cmp({tag, "_frame_count"}, d, 32'(fcnt[d]), 32'd0);
`endif
        end
    endtask

    task automatic model_reset();
        model_clear();
        m_cap = 1'b0;
        m_prev = 1'b0;
        m_count = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        hs_lvl = 1'b0;
        vs_lvl = 1'b0;
        blank = 1'b1;
        colour = '0;
        model_reset();
        tick(4);
        check_zero("reset");
        rst_n = 1'b1;
        tick(3);

        // One line of '1'..'9': the CRC-16/CCITT-FALSE check value.
        vpulse(0);
        line(9, 6'h31, 1);
        m_crc = 16'h29B1;
        vpulse(0);

        // Two good frames: lock on the second.
        good_frame(6'h3c);
        vpulse(0);
        good_frame(6'h3c);
        vpulse(0);

        // Line 3 short by one pixel, then two good frames to relock.
        line(H, 6'h15, 0);
        line(H, 6'h15, 0);
        line(H - 1, 6'h15, 0);
        line(H, 6'h15, 0);
        vpulse(0);
        good_frame(6'h2a);
        vpulse(0);
        good_frame(6'h07);
        vpulse(0);

        // hsync and vsync edges together with 5 pixels open on line 2.
        line(H, 6'h11, 1);
        pixels(5, 6'h22, 1);
        tick();
        vpulse(1);
        good_frame(6'h3c);
        vpulse(0);
        good_frame(6'h3c);
        vpulse(0);

        // Starve vsync past the timeout while locked.
        tick(2 ** TO_LOG2 + 20);
        m_cap = 1'b0;
        m_prev = 1'b0;
        for (int d = 0; d < 2; d++) cmp("timeout_locked", d, 32'(lck[d]), 32'd0);
        vpulse(0);
        good_frame(6'h3c);
        vpulse(0);

        // Reset in the middle of a frame.
        line(H, 6'h05, 0);
        line(H, 6'h05, 0);
        rst_n = 1'b0;
        model_reset();
        tick(3);
        check_zero("midreset");
        rst_n = 1'b1;
        tick(2);
        vpulse(0);
        good_frame(6'h3c);
        vpulse(0);

        for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) tick();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL missing_reports: %0d/%0d still pending, expected 0", q0.size(), q1.size());
        end
        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
